// File: rtl/branch_redirect_ctrl.sv
// Fetch PC sequencer: sequential advance, taken-branch redirect with a fixed flush bubble,
// and a misaligned-target trap that holds until acknowledged.
module branch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC      = 32'h0000_0100,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        ex_valid_in,
   input  logic [4:0]  opcode_6_to_2_in,
   input  logic        branch_taken_in,
   input  logic [31:0] target_addr_in,
   input  logic        stall_in,
   input  logic        fetch_ready_in,
   input  logic        trap_ack_in,
   output logic [31:0] pc_out,
   output logic        fetch_valid_out,
   output logic        flush_out,
   output logic        misaligned_out,
   output logic [31:0] bad_addr_out,
   output logic [15:0] redirect_count_out
);

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] FLUSH = 2'd1;
   localparam logic [1:0] TRAP  = 2'd2;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   logic [1:0]  state;
   logic [2:0]  flush_cnt;
   logic [31:0] pc_q;
   logic [31:0] bad_addr_q;
   logic [15:0] count_q;
   logic        misaligned_q;
   logic        is_ctrl;
   logic        redirect;
   logic [31:0] tgt;

   // The branch unit reports "taken" for every non-control opcode, so qualify it here.
   assign is_ctrl = (opcode_6_to_2_in == 5'b11000) ||
                    (opcode_6_to_2_in == 5'b11011) ||
                    (opcode_6_to_2_in == 5'b11001);

   assign redirect = (state == RUN) & ex_valid_in & is_ctrl & branch_taken_in & ~stall_in;
   assign tgt      = target_addr_in & ~32'h1;

   assign fetch_valid_out    = (state == RUN) & ~stall_in & rst_n_in;
   assign flush_out          = (state == FLUSH);
   assign pc_out             = pc_q;
   assign misaligned_out     = misaligned_q;
   assign bad_addr_out       = bad_addr_q;
   assign redirect_count_out = count_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= RUN;
         flush_cnt    <= 3'd0;
         pc_q         <= RESET_PC;
         bad_addr_q   <= 32'd0;
         count_q      <= 16'd0;
         misaligned_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (redirect) begin
                  if (tgt[1]) begin
                     bad_addr_q   <= tgt;
                     misaligned_q <= 1'b1;
                     state        <= TRAP;
                  end else begin
                     pc_q      <= tgt;
                     flush_cnt <= FLUSH_LOAD;
                     count_q   <= (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                     state     <= FLUSH;
                  end
               end else if (fetch_valid_out && fetch_ready_in) begin
                  pc_q <= pc_q + 32'd4;
               end
            end
            FLUSH: begin
               if (flush_cnt == 3'd0) state <= RUN;
               else                   flush_cnt <= flush_cnt - 3'd1;
            end
            TRAP: begin
               if (trap_ack_in) begin
                  pc_q         <= TRAP_PC;
                  misaligned_q <= 1'b0;
                  flush_cnt    <= FLUSH_LOAD;
                  state        <= FLUSH;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the fetch program counter around the branch unit's decision. Each cycle it qualifies `branch_taken_in` with the execute-stage opcode, because the branch unit drives 1 for non-control opcodes. It then either advances the PC sequentially or redirects it to the resolved target, flushing the younger pipeline stages for a fixed bubble count. Misaligned targets are trapped and held until acknowledged.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `TRAP_PC`, 32'h0000_0100: PC loaded when a misaligned-target trap is acknowledged.
- `FLUSH_CYCLES`, 2: length of the flush bubble after a redirect; legal range 1..7.

Ports:
- `clk_in`  in  1: single clock, rising edge.
- `rst_n_in`  in  1: reset; asynchronous and active-low.
- `ex_valid_in`  in  1: execute stage holds a valid instruction.
- `opcode_6_to_2_in`  in  5: opcode bits [6:2] of the execute-stage instruction.
- `branch_taken_in`  in  1: decision from the branch unit.
- `target_addr_in`  in  32: resolved branch/jump target.
- `stall_in`  in  1: hazard stall; freezes the controller.
- `fetch_ready_in`  in  1: instruction memory accepts a fetch this cycle.
- `trap_ack_in`  in  1: trap handler acknowledges a misaligned trap.
- `pc_out`  out  32: current fetch address.
- `fetch_valid_out`  out  1: fetch request valid.
- `flush_out`  out  1: squash the IF/ID stages.
- `misaligned_out`  out  1: misaligned-target trap pending.
- `bad_addr_out`  out  32: offending target, captured when the trap is taken.
- `redirect_count_out`  out  16: count of accepted redirects.

## Operation
- States: RUN, FLUSH, TRAP. The reset state is RUN.
- `is_ctrl` = opcode is 5'b11000 (BRANCH), 5'b11011 (JAL) or 5'b11001 (JALR). `branch_taken_in` is ignored when `is_ctrl` is 0.
- `redirect` = RUN & `ex_valid_in` & `is_ctrl` & `branch_taken_in` & ~`stall_in`.
- Effective target `tgt` = `target_addr_in` & ~32'h1; bit 0 is always cleared, per JALR semantics.
- RUN:
  - `redirect` with `tgt[1]`=0: `pc_out`<=`tgt`, flush counter <= FLUSH_CYCLES-1, `redirect_count_out`+1 (saturates at 16'hFFFF), go to FLUSH.
  - `redirect` with `tgt[1]`=1: `bad_addr_out`<=`tgt`, `misaligned_out`<=1, go to TRAP. The PC holds and the counter does not increment.
  - Otherwise, if `fetch_valid_out` & `fetch_ready_in`: `pc_out`<=`pc_out`+4, wrapping modulo 2^32.
  - Redirect has priority over the sequential increment.
- FLUSH: all inputs except reset are ignored. `pc_out` holds. The counter decrements each cycle, and the state returns to RUN on the cycle the counter equals 0.
- TRAP: `pc_out` holds. On `trap_ack_in`=1: `pc_out`<=TRAP_PC, `misaligned_out`<=0, go to FLUSH with counter FLUSH_CYCLES-1.
- While `stall_in`=1 in RUN, nothing changes. The stalled instruction is re-presented and evaluated when the stall drops.
- `flush_out` = (state==FLUSH).
- `fetch_valid_out` = (state==RUN) & ~`stall_in` & `rst_n_in`.
- Reset values: `pc_out`=RESET_PC, `flush_out`=0, `misaligned_out`=0, `bad_addr_out`=0, `redirect_count_out`=0, `fetch_valid_out`=0 while reset is asserted.
- Reset asserted mid-FLUSH or mid-TRAP aborts immediately to the reset values.

## Timing
- Redirect accepted at edge k:
  - `pc_out`=target from k+1.
  - `flush_out`=1 for exactly FLUSH_CYCLES cycles (k+1 .. k+FLUSH_CYCLES).
  - `fetch_valid_out` returns to 1 at cycle k+FLUSH_CYCLES+1 if unstalled.
- Sequential fetch: one PC increment per cycle in which both `fetch_valid_out` and `fetch_ready_in` are 1. With `fetch_ready_in`=0 the PC holds and `fetch_valid_out` stays high.
- Misaligned trap: `misaligned_out` and `bad_addr_out` are valid from the edge after detection. `misaligned_out` stays high through the ack edge and clears at the edge where `trap_ack_in` is sampled high.
- `trap_ack_in` is ignored outside TRAP.
- All state updates occur on the rising edge of `clk_in`. The only combinational output is `fetch_valid_out`.

## Test plan
- Reset, then `fetch_ready_in`=1 for 4 cycles, no control opcodes → `pc_out` steps 0,4,8,C,10; `flush_out` stays 0.
- Opcode 5'b01100 with `branch_taken_in`=1 → no redirect; `pc_out` keeps incrementing by 4; `redirect_count_out`=0.
- BEQ taken, target 32'h0000_0040, FLUSH_CYCLES=2 → `pc_out`=40 at the next cycle; `flush_out` high for 2 cycles; `fetch_valid_out` low for 2 cycles; count=1; a second taken branch presented during FLUSH is ignored.
- JALR with target 32'h0000_0063 → `tgt`=62 is misaligned: `misaligned_out`=1, `bad_addr_out`=32'h62, PC holds. Assert `trap_ack_in` → `pc_out`=32'h100, then 2 flush cycles, then RUN.
- JAL taken with `stall_in`=1 for 3 cycles → no change during the stall; redirect taken on the first unstalled cycle.
- Assert reset during FLUSH with `pc_out`=32'h200 → outputs return immediately to reset values; after release, fetch resumes from RESET_PC.
- Preload the counter to 16'hFFFF via 65535 redirects (or force) and take one more redirect → count stays 16'hFFFF.
